// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: a small word FIFO feeding an 8N1-style serialiser.
// Define UART_TX_PARITY_EN to build in the optional parity bit; without it frames never carry parity.
module uart_tx_buf #(
  parameter int CLKS_PER_BIT = 64125000/32/9600,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_BITS-1:0]        in_data,
  input  logic                        parity_en,
  input  logic                        parity_odd,
  input  logic                        two_stop,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        busy,
  output logic                        tx_p
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
    , PARITY = 3'd4
`endif
  } state_t;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;

  state_t               state_q, state_d;
  logic [BW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 two_stop_q, two_stop_d;
  logic                 tx_p_q, tx_p_d;
  logic                 busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
  logic                 par_en_q, par_en_d;
  logic                 par_bit_q, par_bit_d;
`else
  logic                 unused_parity_cfg;
  assign unused_parity_cfg = parity_en ^ parity_odd;
`endif

  logic                 push;
  logic                 pop;
  logic                 bit_end;
  logic                 line;
  logic [DATA_BITS-1:0] head;

  assign in_ready = (count_q != CW'(FIFO_DEPTH));
  assign push     = in_valid && in_ready;
  assign head     = mem_q[rd_ptr_q];
  assign bit_end  = (cnt_q == BW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    two_stop_d = two_stop_q;
`ifdef UART_TX_PARITY_EN
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
`endif
    pop  = 1'b0;
    line = 1'b1;

    if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + BW'(1);
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        pop   = (count_q != '0);
      end
      START: begin
        line = 1'b0;
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        line = shreg_q[0];
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (idx_q == IW'(DATA_BITS - 1)) begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = par_en_q ? PARITY : STOP;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        line = par_bit_q;
        if (bit_end) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        line = 1'b1;
        if (bit_end) begin
          // idx doubles as the stop-bit counter for two-stop frames
          if (two_stop_q && idx_q == '0) begin
            idx_d = IW'(1);
          end else if (count_q != '0) begin
            pop = 1'b1;
          end else begin
            state_d = IDLE;
            idx_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = '0;
        line    = 1'b1;
      end
    endcase

    // Frame configuration is captured together with the word and held until the next pop
    if (pop) begin
      state_d    = START;
      idx_d      = '0;
      cnt_d      = '0;
      shreg_d    = head;
      two_stop_d = two_stop;
`ifdef UART_TX_PARITY_EN
      par_en_d   = parity_en;
      par_bit_d  = (^head) ^ parity_odd;
`endif
    end

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // The line lags the state by one edge, so busy also covers the final stop cycle
    tx_p_d = line;
    busy_d = (state_q != IDLE) || (state_d != IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shreg_q    <= '0;
      two_stop_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_p_q     <= 1'b1;
      busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      two_stop_q <= two_stop_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_p_q     <= tx_p_d;
      busy_q     <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  assign fifo_count = count_q;
  assign busy       = busy_q;
  assign tx_p       = tx_p_q;

endmodule

// File: tb/tb_uart_tx_buf.sv
// Scoreboard bench for uart_tx_buf: pushed words queue expected frames, a line monitor decodes tx_p.
// Parity expectations follow UART_TX_PARITY_EN the same way the design does.
module tb_uart_tx_buf;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       parity_en = 1'b0;
  logic       parity_odd = 1'b0;
  logic       two_stop = 1'b0;
  logic       in_ready;
  logic [2:0] fifo_count;
  logic       busy;
  logic       tx_p;

  uart_tx_buf #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS(8),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .parity_en(parity_en),
    .parity_odd(parity_odd),
    .two_stop(two_stop),
    .fifo_count(fifo_count),
    .busy(busy),
    .tx_p(tx_p)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       po;
    logic       ts;
  } exp_t;

  exp_t sb[$];
  int   starts[$];
  int   frames_done = 0;
  int   last_start = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Line monitor: decodes each frame and checks every bit holds for exactly CPB cycles
  initial begin : monitor
    logic [15:0]    bits;
    logic [CPB-1:0] samp;
    int             nbits;
    int             bi;
    int             si;
    bit             active;
    exp_t           e;
    active = 1'b0;
    nbits = 0;
    bi = 0;
    si = 0;
    samp = '0;
    bits = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 1'b0;
      end else begin
        if (!active && tx_p === 1'b0) begin
          check("frame_expected", (sb.size() != 0), 1);
          e = (sb.size() != 0) ? sb.pop_front() : exp_t'('0);
          bits = '0;
          for (int i = 0; i < 8; i++) bits[1+i] = e.d[i];
          nbits = 9;
`ifdef UART_TX_PARITY_EN
          if (e.pe) begin
            bits[nbits] = (^e.d) ^ e.po;
            nbits++;
          end
`endif
          bits[nbits] = 1'b1;
          nbits++;
          if (e.ts) begin
            bits[nbits] = 1'b1;
            nbits++;
          end
          active = 1'b1;
          bi = 0;
          si = 0;
          last_start = cyc;
          starts.push_back(cyc);
        end
        if (active) begin
          samp[si] = tx_p;
          si++;
          if (si == CPB) begin
            check($sformatf("frame%0d_bit%0d", frames_done, bi), samp, {CPB{bits[bi]}});
            si = 0;
            bi++;
            if (bi == nbits) begin
              active = 1'b0;
              frames_done++;
            end
          end
        end
      end
    end
  end

  task automatic push(input logic [7:0] d, input logic pe, input logic po, input logic ts,
                      output int acc);
    bit   ok;
    bit   done;
    exp_t t;
    done = 1'b0;
    acc = -1;
    in_valid = 1'b1;
    in_data = d;
    parity_en = pe;
    parity_odd = po;
    two_stop = ts;
    for (int i = 0; i < 200 && !done; i++) begin
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) begin
        done = 1'b1;
        acc = cyc;
        t.d = d;
        t.pe = pe;
        t.po = po;
        t.ts = ts;
        sb.push_back(t);
      end
    end
    in_valid = 1'b0;
    $display("push 0x%02h pe=%0d po=%0d ts=%0d accepted=%0d at cycle %0d", d, pe, po, ts, done, acc);
    check("push_accepted", done, 1);
  endtask

  task automatic wait_frames(input int n);
    for (int i = 0; i < 2000 && frames_done < n; i++) begin
      @(posedge clk);
      #1;
    end
    check("frames_done", frames_done, n);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int acc;
    int acc1;
    int acc6;
    int a;

    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("rst_tx_p", tx_p, 1);
    check("rst_in_ready", in_ready, 1);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 0x55, no parity, one stop
    push(8'h55, 1'b0, 1'b0, 1'b0, acc);
    check("fc_after_first_push", fifo_count, 1);
    check("busy_after_push", busy, 1);
    wait_frames(1);
    check("start_latency", last_start - acc, 2);

    // 0xA5 even then odd parity; config changes while the first frame is in flight
    push(8'hA5, 1'b1, 1'b0, 1'b0, acc);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    push(8'hA5, 1'b1, 1'b1, 1'b0, a);
    wait_frames(3);

    // 0x00 with two stop bits: busy drops right after the 8 stop cycles
    push(8'h00, 1'b0, 1'b0, 1'b1, acc);
    wait_cyc(acc + 45);
    check("busy_last_stop_cycle", busy, 1);
    check("tx_last_stop_cycle", tx_p, 1);
    @(posedge clk);
    #1;
    check("busy_after_stop", busy, 0);
    check("tx_idle_after_stop", tx_p, 1);
    wait_frames(4);

    // six back-to-back pushes: fill, stall while full, wrap pointers
    push(8'h01, 1'b0, 1'b0, 1'b0, acc1);
    check("fc_b2b_1", fifo_count, 1);
    push(8'h02, 1'b0, 1'b0, 1'b0, a);
    check("fc_push_pop_same_edge", fifo_count, 1);
    push(8'h03, 1'b0, 1'b0, 1'b0, a);
    check("fc_b2b_3", fifo_count, 2);
    push(8'h04, 1'b0, 1'b0, 1'b0, a);
    check("fc_b2b_4", fifo_count, 3);
    push(8'h05, 1'b0, 1'b0, 1'b0, a);
    check("fc_full", fifo_count, 4);
    check("in_ready_full", in_ready, 0);
    push(8'h06, 1'b0, 1'b0, 1'b0, acc6);
    check("fc_refill", fifo_count, 4);
    check("full_refuses_on_pop_edge", acc6 - acc1, 42);
    wait_frames(10);
    for (int i = 5; i < 10; i++) begin
      check($sformatf("gap_frame%0d", i), starts[i] - starts[i-1], CPB * 10);
    end

    // reset in the middle of data bit 3 with a word still queued; push during reset is ignored
    push(8'h96, 1'b0, 1'b0, 1'b0, acc);
    push(8'h69, 1'b0, 1'b0, 1'b0, a);
    wait_cyc(acc + 19);
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hEE;
    @(posedge clk);
    #1;
    check("midframe_rst_tx_p", tx_p, 1);
    check("midframe_rst_fifo_count", fifo_count, 0);
    check("midframe_rst_in_ready", in_ready, 1);
    check("midframe_rst_busy", busy, 0);
    rst = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    repeat (60) begin
      @(posedge clk);
      #1;
    end
    check("no_frame_after_rst", frames_done, 10);
    check("idle_tx_after_rst", tx_p, 1);

    // recovery frame with odd parity and two stops
    push(8'h3C, 1'b1, 1'b1, 1'b1, acc);
    wait_frames(11);
    check("scoreboard_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
